pipelined_decode_ctrl: RTL and testbench
========================================

Name: pipelined_decode_ctrl

Overview:
- Registered, handshaked successor to the combinational control decoder of the 8-bit processor.
- Decodes opcode/func into datapath controls and holds them in the ID/EX control register.
- Detects load-use hazards and inserts bubbles; squashes the instruction after a taken jump; flags illegal encodings.
- Sits between the fetch/decode field extractor and the execute stage.

Parameters:
- OPW, 4, opcode width
- FW, 3, func width
- RAW, 3, register address width
- SCW, 8, width of the saturating stall counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode fields valid
- in_ready  out  1  block accepts fields this cycle
- opcode  in  OPW  instruction opcode
- func  in  FW  R-type function
- rs1, rs2, rd  in  RAW  register addresses
- out_valid  out  1  control register holds a real instruction
- out_ready  in  1  execute stage accepts
- reg_write, alu_src, mem_write, mem_to_reg, jump, r2_chooser  out  1  registered controls
- alu_ctrl  out  3  ALU operation
- out_rd  out  RAW  registered destination
- illegal  out  1  current output is an illegal encoding
- illegal_seen  out  1  sticky illegal flag, cleared only by rst
- stall_count  out  SCW  saturating count of hazard bubbles

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FSM=RUN. Reset mid-stall or mid-squash aborts the stall or squash.
- Decode table:
  - opcode 0000 with func 000..110: alu_ctrl=func, reg_write=1, all other controls 0.
  - 0100 ADDI: alu_src=1, reg_write=1.
  - 1011 LW: alu_src=1, mem_to_reg=1, reg_write=1.
  - 1111 SW: alu_src=1, mem_write=1, r2_chooser=1.
  - 1000 BEQ: alu_ctrl=111, r2_chooser=1.
  - 0010 JMP: alu_ctrl=111, alu_src=1, jump=1.
  - Any other opcode, or 0000 with func 111: every control 0 and illegal=1. This is an accepted instruction with out_valid=1.
- Latency: one cycle from handshake to registered output.
- Output hold: out_valid=1 and out_ready=0 freezes all output registers.
- Hazard (comb):
  - Conditions: out_valid=1, mem_to_reg=1, out_rd≠0, in_valid=1, and either out_rd==rs1, or out_rd==rs2 for opcodes 0000/1111/1000.
  - Effect: in_ready=0. On the next edge with out_ready=1, load a bubble (out_valid=0, controls 0) and increment stall_count, saturating at all-ones.
- in_ready = !hazard && (!out_valid || out_ready).
- FSM states: RUN, SQUASH.
  - RUN→SQUASH when a JMP is accepted.
  - In SQUASH, the next accepted instruction is discarded (out_valid←0, no illegal update), then →RUN.
  - SQUASH persists across in_valid=0 cycles.
  - A JMP accepted in SQUASH is itself discarded, and the FSM goes →RUN.
- Outputs update only on handshake, bubble, or drain. Drain: out_ready=1 with no new input sets out_valid←0.
- illegal_seen←1 when an illegal instruction is loaded.

Decomposition:
- Package ctrl_pkg: opcode constants, alu_op_e enum (ADD..PASS=111), ctrl_t struct bundling the seven controls, CTRL_NOP constant.
- One combinational sub-module, ctrl_decode (opcode, func → ctrl_t plus illegal). The top holds the registers, hazard logic and FSM.

Test Plan:
- rst after random traffic → every output 0. Then ADD (0000/000, rd=2) with out_ready=1 → next cycle out_valid=1, reg_write=1, alu_ctrl=000, out_rd=2.
- LW rd=3, then ADD rs1=3 → one bubble cycle (out_valid=0, in_ready=0), stall_count=1, ADD appears one cycle later. Repeat with rd=0 → no stall.
- JMP followed by SW → JMP output jump=1; SW discarded (out_valid=0); following ADDI emitted normally (alu_src=1, reg_write=1).
- out_ready=0 for 3 cycles with BEQ loaded → outputs frozen (alu_ctrl=111, r2_chooser=1), in_ready=0; release → next instruction loads.
- opcode 0101, then 0000/111 → illegal=1, controls 0, illegal_seen stays 1 after a following legal ADD.
- Force 2^SCW+2 load-use stalls → stall_count saturates at 255. Assert rst during SQUASH → the next instruction is not discarded.

Source files
------------

// File: rtl/pipelined_decode_ctrl_pkg.sv
// Shared opcode encodings, ALU operation codes and the control bundle
// carried from decode into the ID/EX control register.
package ctrl_pkg;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0100;
   localparam logic [3:0] OP_LW    = 4'b1011;
   localparam logic [3:0] OP_SW    = 4'b1111;
   localparam logic [3:0] OP_BEQ   = 4'b1000;
   localparam logic [3:0] OP_JMP   = 4'b0010;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_SLL  = 3'b110,
      ALU_PASS = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    alu_src;
      logic    mem_write;
      logic    mem_to_reg;
      logic    jump;
      logic    r2_chooser;
      alu_op_e alu_ctrl;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   typedef enum logic {S_RUN, S_SQUASH} state_e;

endpackage

// File: rtl/pipelined_decode_ctrl_decode.sv
// Combinational opcode/func decoder producing the control bundle and an
// illegal-encoding flag; illegal encodings yield an all-zero bundle.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 4,
   parameter int FW  = 3
) (
   input  logic [OPW-1:0] opcode,
   input  logic [FW-1:0]  func,
   output ctrl_t          ctrl,
   output logic           illegal
);

   always_comb begin
      ctrl    = CTRL_NOP;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (func == 3'b111) begin
               illegal = 1'b1;
            end else begin
               ctrl.alu_ctrl  = alu_op_e'(func);
               ctrl.reg_write = 1'b1;
            end
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_write  = 1'b1;
            ctrl.r2_chooser = 1'b1;
         end
         OP_BEQ: begin
            ctrl.alu_ctrl   = ALU_PASS;
            ctrl.r2_chooser = 1'b1;
         end
         OP_JMP: begin
            ctrl.alu_ctrl = ALU_PASS;
            ctrl.alu_src  = 1'b1;
            ctrl.jump     = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipelined_decode_ctrl.sv
// ID/EX control register with valid/ready handshake, load-use bubble
// insertion, post-jump squash FSM and sticky illegal-encoding tracking.
module pipelined_decode_ctrl
   import ctrl_pkg::*;
#(
   parameter int OPW = 4,
   parameter int FW  = 3,
   parameter int RAW = 3,
   parameter int SCW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] opcode,
   input  logic [FW-1:0]  func,
   input  logic [RAW-1:0] rs1,
   input  logic [RAW-1:0] rs2,
   input  logic [RAW-1:0] rd,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           reg_write,
   output logic           alu_src,
   output logic           mem_write,
   output logic           mem_to_reg,
   output logic           jump,
   output logic           r2_chooser,
   output logic [2:0]     alu_ctrl,
   output logic [RAW-1:0] out_rd,
   output logic           illegal,
   output logic           illegal_seen,
   output logic [SCW-1:0] stall_count
);

   function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   ctrl_t          dec_ctrl;
   logic           dec_illegal;
   logic           uses_rs2;
   logic           hazard;
   logic           accept;
   state_e         state_q, state_n;

   logic           vld_p1;
   ctrl_t          ctrl_p1;
   logic [RAW-1:0] rd_p1;
   logic           ill_p1;
   logic           ill_seen_q;
   logic [SCW-1:0] stall_q;

   ctrl_decode #(.OPW(OPW), .FW(FW)) u_decode (
      .opcode  (opcode),
      .func    (func),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   // rs2 only matters for encodings that actually read it as a register
   assign uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
   assign hazard   = vld_p1 && ctrl_p1.mem_to_reg && (rd_p1 != '0) && in_valid &&
                     ((rd_p1 == rs1) || (uses_rs2 && (rd_p1 == rs2)));
   assign in_ready = !hazard && (!vld_p1 || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_n = state_q;
      if (accept) begin
         if (state_q == S_SQUASH)  state_n = S_RUN;
         else if (dec_ctrl.jump)   state_n = S_SQUASH;
      end
   end

   // ---- stage p1: ID/EX control register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         vld_p1     <= 1'b0;
         ctrl_p1    <= CTRL_NOP;
         rd_p1      <= '0;
         ill_p1     <= 1'b0;
         ill_seen_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q <= state_n;
         if (accept && (state_q == S_SQUASH)) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_NOP;
            rd_p1   <= '0;
            ill_p1  <= 1'b0;
         end else if (accept) begin
            vld_p1     <= 1'b1;
            ctrl_p1    <= dec_ctrl;
            rd_p1      <= rd;
            ill_p1     <= dec_illegal;
            ill_seen_q <= ill_seen_q | dec_illegal;
         end else if (out_ready) begin
            // bubble on a load-use hazard, plain drain otherwise
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_NOP;
            rd_p1   <= '0;
            ill_p1  <= 1'b0;
            if (hazard) stall_q <= sat_inc(stall_q);
         end
      end
   end

   assign out_valid    = vld_p1;
   assign reg_write    = ctrl_p1.reg_write;
   assign alu_src      = ctrl_p1.alu_src;
   assign mem_write    = ctrl_p1.mem_write;
   assign mem_to_reg   = ctrl_p1.mem_to_reg;
   assign jump         = ctrl_p1.jump;
   assign r2_chooser   = ctrl_p1.r2_chooser;
   assign alu_ctrl     = ctrl_p1.alu_ctrl;
   assign out_rd       = rd_p1;
   assign illegal      = ill_p1;
   assign illegal_seen = ill_seen_q;
   assign stall_count  = stall_q;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Directed bench for pipelined_decode_ctrl: handshake, hazards, squash,
// output hold, illegal flags and stall counter saturation.
module tb_pipelined_decode_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [2:0] func;
   logic [2:0] rs1, rs2, rd;
   logic       out_valid;
   logic       out_ready;
   logic       reg_write, alu_src, mem_write, mem_to_reg, jump, r2_chooser;
   logic [2:0] alu_ctrl;
   logic [2:0] out_rd;
   logic       illegal, illegal_seen;
   logic [7:0] stall_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipelined_decode_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .func         (func),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .reg_write    (reg_write),
      .alu_src      (alu_src),
      .mem_write    (mem_write),
      .mem_to_reg   (mem_to_reg),
      .jump         (jump),
      .r2_chooser   (r2_chooser),
      .alu_ctrl     (alu_ctrl),
      .out_rd       (out_rd),
      .illegal      (illegal),
      .illegal_seen (illegal_seen),
      .stall_count  (stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setin(input logic v, input logic [3:0] op, input logic [2:0] fn,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
      in_valid = v; opcode = op; func = fn; rs1 = a; rs2 = b; rd = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {reg_write,alu_src,mem_write,mem_to_reg,jump,r2_chooser,alu_ctrl}
   function automatic logic [8:0] ctrls();
      return {reg_write, alu_src, mem_write, mem_to_reg, jump, r2_chooser, alu_ctrl};
   endfunction

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      setin(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         setin(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      setin(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      chk("reset_outputs", {out_valid, ctrls(), out_rd, illegal, illegal_seen, stall_count}, 32'h0);
      chk("reset_in_ready", in_ready, 1'b1);

      // ADD rd=2
      setin(1'b1, 4'b0000, 3'b000, 3'd1, 3'd1, 3'd2);
      tick();
      chk("add_valid", out_valid, 1'b1);
      chk("add_ctrls", ctrls(), 9'b1_0000_0_000);
      chk("add_rd", out_rd, 3'd2);

      // LW rd=3 then ADD rs1=3: one bubble
      setin(1'b1, 4'b1011, 3'b000, 3'd0, 3'd0, 3'd3);
      tick();
      chk("lw_ctrls", ctrls(), 9'b1_1010_0_000);
      setin(1'b1, 4'b0000, 3'b000, 3'd3, 3'd0, 3'd4);
      chk("hazard_in_ready", in_ready, 1'b0);
      tick();
      chk("bubble_valid", out_valid, 1'b0);
      chk("bubble_ctrls", ctrls(), 9'h0);
      chk("bubble_stall", stall_count, 8'd1);
      chk("after_bubble_in_ready", in_ready, 1'b1);
      tick();
      chk("add_after_bubble", {out_valid, reg_write, out_rd}, {1'b1, 1'b1, 3'd4});

      // LW rd=0: no stall
      setin(1'b1, 4'b1011, 3'b000, 3'd0, 3'd0, 3'd0);
      tick();
      setin(1'b1, 4'b0000, 3'b000, 3'd0, 3'd0, 3'd4);
      chk("rd0_in_ready", in_ready, 1'b1);
      tick();
      chk("rd0_no_stall", {out_valid, out_rd, stall_count}, {1'b1, 3'd4, 8'd1});

      // JMP, SW discarded, ADDI emitted
      setin(1'b1, 4'b0010, 3'b000, 3'd0, 3'd0, 3'd0);
      tick();
      chk("jmp_ctrls", {out_valid, ctrls()}, {1'b1, 9'b0_1001_0_111});
      setin(1'b1, 4'b1111, 3'b000, 3'd1, 3'd2, 3'd0);
      tick();
      chk("sw_squashed", {out_valid, mem_write}, 2'b00);
      setin(1'b1, 4'b0100, 3'b000, 3'd1, 3'd0, 3'd5);
      tick();
      chk("addi_after_squash", {out_valid, ctrls(), out_rd}, {1'b1, 9'b1_1000_0_000, 3'd5});

      // BEQ held while out_ready=0
      setin(1'b1, 4'b1000, 3'b000, 3'd1, 3'd2, 3'd0);
      tick();
      out_ready = 1'b0;
      setin(1'b1, 4'b0000, 3'b000, 3'd1, 3'd1, 3'd6);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("beq_hold", {out_valid, ctrls(), in_ready}, {1'b1, 9'b0_0000_1_111, 1'b0});
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1'b1);
      tick();
      chk("after_release", {out_valid, reg_write, out_rd}, {1'b1, 1'b1, 3'd6});

      // illegal encodings
      setin(1'b1, 4'b0101, 3'b000, 3'd0, 3'd0, 3'd1);
      tick();
      chk("illegal_op", {out_valid, illegal, illegal_seen, ctrls()}, {3'b111, 9'h0});
      setin(1'b1, 4'b0000, 3'b111, 3'd0, 3'd0, 3'd1);
      tick();
      chk("illegal_func", {out_valid, illegal, illegal_seen, ctrls()}, {3'b111, 9'h0});
      setin(1'b1, 4'b0000, 3'b000, 3'd0, 3'd0, 3'd1);
      tick();
      chk("sticky_illegal", {out_valid, illegal, illegal_seen, reg_write}, 4'b1011);

      // drain
      setin(1'b0, 4'b0000, 3'b000, 3'd0, 3'd0, 3'd0);
      tick();
      chk("drain", out_valid, 1'b0);

      // squash persists across idle cycles
      setin(1'b1, 4'b0010, 3'b000, 3'd0, 3'd0, 3'd0);
      tick();
      setin(1'b0, 4'b0000, 3'b000, 3'd0, 3'd0, 3'd0);
      tick();
      tick();
      setin(1'b1, 4'b0100, 3'b000, 3'd0, 3'd0, 3'd2);
      tick();
      chk("squash_persist", out_valid, 1'b0);
      setin(1'b1, 4'b0000, 3'b001, 3'd0, 3'd0, 3'd2);
      tick();
      chk("run_after_squash", {out_valid, alu_ctrl, out_rd}, {1'b1, 3'd1, 3'd2});

      // stall counter saturation: 258 more load-use stalls
      for (int i = 0; i < 258; i++) begin
         setin(1'b1, 4'b1011, 3'b000, 3'd0, 3'd0, 3'd3);
         tick();
         setin(1'b1, 4'b0000, 3'b000, 3'd3, 3'd0, 3'd4);
         tick();
         tick();
         if (i == 253) chk("stall_at_255", stall_count, 8'd255);
      end
      chk("stall_saturated", stall_count, 8'd255);
      chk("sat_last_add", {out_valid, out_rd}, {1'b1, 3'd4});

      // reset during squash
      setin(1'b1, 4'b0010, 3'b000, 3'd0, 3'd0, 3'd0);
      tick();
      chk("jmp_before_rst", jump, 1'b1);
      setin(1'b0, 4'b0000, 3'b000, 3'd0, 3'd0, 3'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_squash", {out_valid, ctrls(), out_rd, illegal, illegal_seen, stall_count}, 32'h0);
      setin(1'b1, 4'b0000, 3'b001, 3'd0, 3'd0, 3'd7);
      tick();
      chk("no_discard_after_rst", {out_valid, alu_ctrl, reg_write, out_rd}, {1'b1, 3'd1, 1'b1, 3'd7});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
